// File: rtl/pc_vec_unit.sv
// pc_vec_unit: program counter with prioritised vectored interrupts and a nesting return-address stack.
module pc_vec_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(32'h0000_00CC),
    parameter int               VEC_STRIDE = 4,
    parameter int               N_INT      = 4,
    parameter int               EPC_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pc_write,
    input  logic [WIDTH-1:0] i_npc,
    input  logic [WIDTH-1:0] i_epc_in,
    input  logic [N_INT-1:0] i_irq,
    input  logic             i_int_en,
    input  logic             i_eret,
    input  logic             i_eretn,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_int_ack,
    output logic [2:0]       o_int_id,
    output logic [3:0]       o_depth,
    output logic             o_in_service,
    output logic             o_eret_err
);
    localparam int AW = (EPC_DEPTH > 1) ? $clog2(EPC_DEPTH) : 1;
    logic [WIDTH-1:0] r_epc [0:(1<<AW)-1];
    logic [2:0]       r_lvl [0:(1<<AW)-1];
    logic [WIDTH-1:0] r_pc;
    logic             r_ack, r_err;
    logic [2:0]       r_id;
    logic [3:0]       r_depth;
    logic [AW-1:0]    w_push, w_top, w_below;
    logic [3:0]       w_cur_lvl;
    logic             w_hit, w_take, w_ret, w_empty;
    logic [2:0]       w_sel;
    assign w_push    = r_depth[AW-1:0];
    assign w_top     = w_push - AW'(1);
    assign w_below   = w_push - AW'(2);
    assign w_empty   = r_depth == 4'd0;
    assign w_cur_lvl = w_empty ? 4'(N_INT) : {1'b0, r_lvl[w_top]};
    // Scan downwards so the lowest-numbered eligible line wins.
    always_comb begin
        w_hit = 1'b0;
        w_sel = 3'd0;
        for (int k = N_INT - 1; k >= 0; k--) begin
            if (i_irq[k] && 4'(k) < w_cur_lvl) begin
                w_hit = 1'b1;
                w_sel = 3'(k);
            end
        end
    end
    assign w_take = i_int_en && w_hit && r_depth < 4'(EPC_DEPTH);
    assign w_ret  = !w_take && (i_eret || i_eretn);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_VEC;
            r_depth <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_id    <= 3'd0;
            for (int k = 0; k < (1 << AW); k++) begin
                r_epc[k] <= '0;
                r_lvl[k] <= 3'd0;
            end
        end else begin
            r_ack <= w_take;
            r_err <= w_ret && w_empty;
            if (w_take) begin
                r_epc[w_push] <= i_epc_in;
                r_lvl[w_push] <= w_sel;
                r_depth       <= r_depth + 4'd1;
                r_pc          <= VEC_BASE + WIDTH'(w_sel) * WIDTH'(VEC_STRIDE);
                r_id          <= w_sel;
            end else if (w_ret) begin
                if (!w_empty) begin
                    r_depth <= r_depth - 4'd1;
                    r_pc    <= r_epc[w_top] + (i_eretn ? WIDTH'(4) : '0);
                    r_id    <= (r_depth > 4'd1) ? r_lvl[w_below] : 3'd0;
                end
            end else if (i_pc_write) begin
                r_pc <= i_npc;
            end
        end
    end
    assign o_pc         = r_pc;
    assign o_int_ack    = r_ack;
    assign o_int_id     = r_id;
    assign o_depth      = r_depth;
    assign o_in_service = !w_empty;
    assign o_eret_err   = r_err;
endmodule
